// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl_if
//  Description : Request/result bundle for the nibble-serial 16-bit adder.
//                The sub signal exists only when ADD_SUB_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface nibble_serial_add_ctrl_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef ADD_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

`ifdef ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input  start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input  start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl
//  Description : 16-bit adder built from one 4-bit ripple slice reused over
//                four cycles (IDLE -> RUN x4 -> DONE). Optional subtract
//                support is compiled in with the ADD_SUB_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_add_ctrl (
  input  wire logic               clk,
  input  wire logic               rst,
  nibble_serial_add_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;       // operand B already inverted for subtract
  logic [15:0] sum_q, sum_d;
  logic        carry_q, carry_d;
  logic [1:0]  idx_q, idx_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic [15:0] b_eff;
  logic        cin_eff;
  logic [3:0]  a_nib, b_nib, s_nib;
  logic        c_nib;
  logic [3:0]  nib_base;

  // Effective operand B and carry-in as captured on an accepting edge
  always_comb begin
`ifdef ADD_SUB_EN
    b_eff   = bus.sub ? ~bus.b : bus.b;
    cin_eff = bus.sub ? 1'b1   : bus.cin;
`else
    b_eff   = bus.b;
    cin_eff = bus.cin;
`endif
  end

  // The single 4-bit ripple slice, fed by the nibble selected by idx
  assign nib_base         = {idx_q, 2'b00};
  assign a_nib            = a_q[nib_base +: 4];
  assign b_nib            = b_q[nib_base +: 4];
  assign {c_nib, s_nib}   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

  // Next-state and datapath update; everything holds unless changed below
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_eff;
          carry_d = cin_eff;
          idx_d   = 2'd0;
          sum_d   = 16'h0000;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[nib_base +: 4] = s_nib;
        carry_d              = c_nib;
        idx_d                = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          cout_d  = c_nib;
          // carry into bit 15 recovered from the top bit's sum equation
          ovf_d   = (a_nib[3] ^ b_nib[3] ^ s_nib[3]) ^ c_nib;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      sum_q   <= 16'h0000;
      carry_q <= 1'b0;
      idx_q   <= 2'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire
